rshift_seq_unit: RTL

Multi-cycle 16-bit right-shift unit for the accumulator datapath: the right-direction counterpart of the fixed left-shift (`<< 12`) block. It accepts an operand and a 4-bit shift amount on a start strobe, then shifts iteratively. Each cycle moves 4 bits while at least 4 remain, otherwise 1 bit. It presents the result with a one-cycle done pulse. It sits beside the ALU and is sequenced by the control unit through a start/busy/done handshake.

---
 rtl/rshift_seq_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/rshift_seq_unit.sv
// Multi-cycle 16-bit right shifter: 4 bits per cycle while at least 4 remain, then 1 bit per cycle.
// Define RSHIFT_ARITH_EN to honour the arith input (sign-fill); otherwise every shift zero-fills.
module rshift_seq_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [3:0]       shamt,
  input  logic             arith,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fill_bit;

`ifdef RSHIFT_ARITH_EN
  logic fill_q, fill_d;

  // The MSB survives an arithmetic shift, so it always carries the original sign.
  assign fill_bit = fill_q & acc_q[WIDTH-1];
`else
  logic unused_arith;

  assign unused_arith = arith;
  assign fill_bit     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef RSHIFT_ARITH_EN
    fill_d  = fill_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = a;
          cnt_d   = shamt;
          busy_d  = 1'b1;
          state_d = StShift;
`ifdef RSHIFT_ARITH_EN
          fill_d  = arith;
`endif
        end
      end
      StShift: begin
        if (cnt_q >= 4'd4) begin
          acc_d = {{4{fill_bit}}, acc_q[WIDTH-1:4]};
          cnt_d = cnt_q - 4'd4;
        end else if (cnt_q != 4'd0) begin
          acc_d = {fill_bit, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RSHIFT_ARITH_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef RSHIFT_ARITH_EN
      fill_q  <= fill_d;
`endif
    end
  end

  assign r    = acc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
